seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Sequential restoring divider; the inverse of the team's 4x4 Wallace multiplier.
- Takes a 2N-bit dividend and an N-bit divisor. Produces a 2N-bit quotient and an N-bit remainder, one quotient bit per clock.
- Used to undo or check product results in the arithmetic datapath.
- Uses a start/busy/done handshake toward the requesting controller.

Parameters:
- N, 4, divisor and remainder width; dividend and quotient width is 2N.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only when busy=0
- dividend  input  2N  numerator, captured on an accepted start
- divisor  input  N  denominator, captured on an accepted start
- busy  output  1  high in RUN and DONE states
- done  output  1  one-cycle pulse; quotient and remainder valid
- quotient  output  2N  result; holds until the next accepted start
- remainder  output  N  result; holds until the next accepted start
- dbz  output  1  divide-by-zero flag for the last operation
- chk_err  output  1  self-check mismatch (see Optional Feature)

Behaviour:
- Clock and reset:
  - One clock domain; reset is synchronous and active-high.
  - rst=1 at a clock edge forces state IDLE and clears all internal registers.
  - Reset values: busy=0, done=0, quotient=0, remainder=0, dbz=0, chk_err=0.
  - rst overrides everything, including mid-operation; an aborted operation never produces a done.
- States:
  - IDLE -> RUN on start=1 with divisor!=0.
  - IDLE -> DONE on start=1 with divisor==0.
  - RUN -> DONE after the 2N-th step.
  - DONE -> IDLE unconditionally after 1 cycle.
- Accept (IDLE, start=1, at edge E0):
  - Load working dividend register Q<=dividend, partial remainder R<=0, divisor register D<=divisor, step counter<=2N.
  - Clear dbz.
- Step (RUN, one per edge, edges E0+1 .. E0+2N):
  - T = {R, Q[2N-1]}, N+1 bits.
  - If T >= {1'b0, D}: R <= T - D (low N bits) and Q <= {Q[2N-2:0], 1}.
  - Otherwise: R <= T[N-1:0] and Q <= {Q[2N-2:0], 0}.
  - Counter decrements; the step taken when counter==1 also moves the state to DONE.
- Results (DONE):
  - quotient<=Q and remainder<=R are registered on entry.
  - done=1 for exactly one cycle, the cycle after edge E0+2N. For N=4 that is 8 edges after the start edge.
- Divide by zero:
  - No steps are performed; DONE is entered at E0, so done is high in the cycle right after start.
  - quotient = all ones; remainder = dividend[N-1:0]; dbz=1.
- Handshake:
  - start is ignored while busy=1 (RUN or DONE); no queuing.
  - A new start is accepted in the IDLE cycle after DONE, so back-to-back throughput is one operation every 2N+2 cycles.
  - Inputs only need to be valid in the accept cycle.
- Arithmetic: unsigned only. Invariant for divisor!=0: quotient*divisor + remainder == dividend, with remainder < divisor.

Optional Feature:
- Macro: SEQ_DIVIDER_CHECK_EN.
- Defined:
  - In DONE with dbz=0, a combinational multiply-add computes quotient*divisor_reg + remainder.
  - The result is compared with the captured dividend; chk_err is registered high for 1 cycle (aligned with the cycle after done) on mismatch.
  - The check is skipped when dbz=1.
- Undefined: chk_err is tied 0 and no check logic exists. Port list is identical in both builds.

Test Plan:
- N=4, dividend=200, divisor=13, start 1 cycle -> done 8 cycles later, quotient=15, remainder=5, dbz=0, busy high 9 cycles.
- dividend=255, divisor=15 -> quotient=17, remainder=0; then dividend=225, divisor=1 back-to-back in the next IDLE cycle -> quotient=225, remainder=0.
- dividend=7, divisor=9 -> quotient=0, remainder=7; start pulsed again during RUN -> ignored, result unchanged, only one done.
- dividend=100, divisor=0 -> done in the cycle after start, quotient=255, remainder=4, dbz=1; the following normal op clears dbz.
- rst asserted at step 3 of 200/13 -> next cycle busy=0, quotient=0, remainder=0, no done; a new start after reset gives the correct result.
- SEQ_DIVIDER_CHECK_EN defined, exhaustive sweep of all 256x15 non-zero operand pairs -> chk_err never asserts; all results match a reference model.

Source files
------------

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Sequential restoring divider: 2N-bit dividend / N-bit divisor, producing a
//   2N-bit quotient and an N-bit remainder, one quotient bit per clock.
//   A start/busy/done handshake is used toward the requesting controller.
//
//   Optional build macro: SEQ_DIVIDER_CHECK_EN
//     Defined   : the result is multiplied back (quotient*divisor + remainder)
//                 while in DONE and compared with the captured dividend;
//                 chk_err pulses for one cycle, in the cycle after done, on
//                 a mismatch. Divide-by-zero results are not checked.
//     Undefined : chk_err is tied low and no check logic is built.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset
//   start      in   1   request, sampled only while busy=0
//   dividend   in   2N  numerator, captured on an accepted start
//   divisor    in   N   denominator, captured on an accepted start
//   busy       out  1   high in RUN and DONE
//   done       out  1   one-cycle pulse, quotient/remainder valid
//   quotient   out  2N  result, held until the next completion
//   remainder  out  N   result, held until the next completion
//   dbz        out  1   divide-by-zero flag for the last operation
//   chk_err    out  1   self-check mismatch pulse (see macro above)
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int N = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2*N-1:0]  dividend,
    input  logic [N-1:0]    divisor,
    output logic            busy,
    output logic            done,
    output logic [2*N-1:0]  quotient,
    output logic [N-1:0]    remainder,
    output logic            dbz,
    output logic            chk_err
);

    localparam int W  = 2 * N;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   q_q, q_d;       // working dividend, shifts into quotient
    logic [N-1:0]   r_q, r_d;       // partial remainder
    logic [N-1:0]   d_q, d_d;       // captured divisor
    logic [CW-1:0]  cnt_q, cnt_d;   // steps still to perform
    logic [W-1:0]   quo_q, quo_d;
    logic [N-1:0]   rem_q, rem_d;
    logic           dbz_q, dbz_d;

    logic           accept;
    logic [N:0]     trial;
    logic [N:0]     diff;

    assign accept = (state_q == S_IDLE) && start;

    // Trial value: partial remainder with the next dividend bit shifted in.
    // It is one bit wider than the divisor so the compare never overflows.
    assign trial = {r_q, q_q[W-1]};
    assign diff  = trial - {1'b0, d_q};

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    q_d   = dividend;
                    r_d   = '0;
                    d_d   = divisor;
                    cnt_d = CW'(W);
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        // No steps: results are defined directly.
                        state_d = S_DONE;
                        quo_d   = '1;
                        rem_d   = dividend[N-1:0];
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (trial >= {1'b0, d_q}) begin
                    r_d = diff[N-1:0];
                    q_d = {q_q[W-2:0], 1'b1};
                end else begin
                    r_d = trial[N-1:0];
                    q_d = {q_q[W-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    // Last step: publish the freshly computed values.
                    state_d = S_DONE;
                    quo_d   = q_d;
                    rem_d   = r_d;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign dbz       = dbz_q;

`ifdef SEQ_DIVIDER_CHECK_EN
    localparam int PW = 3 * N;

    logic [W-1:0]  dvd_q;
    logic [PW-1:0] recon;
    logic          chk_err_q;

    assign recon = PW'(quo_q) * PW'(d_q) + PW'(rem_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q     <= '0;
            chk_err_q <= 1'b0;
        end else begin
            if (accept) begin
                dvd_q <= dividend;
            end
            chk_err_q <= (state_q == S_DONE) && !dbz_q && (recon != PW'(dvd_q));
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam int N = 4;
    localparam int W = 2 * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  dividend;
    logic [N-1:0]  divisor;
    logic          busy;
    logic          done;
    logic [W-1:0]  quotient;
    logic [N-1:0]  remainder;
    logic          dbz;
    logic          chk_err;

    int total = 0;
    int bad   = 0;
    int chk_err_hits = 0;

    seq_divider #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .chk_err   (chk_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chk_err === 1'b1) chk_err_hits++;
    end

    typedef struct {
        logic [W-1:0] a;
        logic [N-1:0] b;
        logic [W-1:0] q;
        logic [N-1:0] r;
        logic         z;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division; divide-by-zero returns all ones and
    // the low N bits of the dividend.
    task automatic ref_div(input logic [W-1:0] a, input logic [N-1:0] b,
                           output logic [W-1:0] q, output logic [N-1:0] r,
                           output logic z);
        int ai, bi;
        ai = int'(a);
        bi = int'(b);
        if (bi == 0) begin
            q = '1;
            r = a[N-1:0];
            z = 1'b1;
        end else begin
            q = W'(ai / bi);
            r = N'(ai % bi);
            z = 1'b0;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // IDLE cycle following done, so the next call starts back-to-back.
    // glitch_at >= 0 pulses start (with other operands) at that cycle.
    task automatic do_op(input logic [W-1:0] a, input logic [N-1:0] b,
                         input logic [W-1:0] eq, input logic [N-1:0] er,
                         input logic ez, input int glitch_at);
        int  cyc;
        int  busy_n;
        bit  seen;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        cyc    = 0;
        busy_n = 0;
        seen   = 0;
        while (!seen && cyc < 20) begin
            if (busy) busy_n++;
            if (done) begin
                seen = 1;
            end else begin
                if (cyc == glitch_at) begin
                    start    = 1'b1;
                    dividend = 8'd200;
                    divisor  = 4'd13;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("done_cycle", 32'(cyc), ez ? 32'd0 : 32'd8);
            check("busy_cycles", 32'(busy_n), ez ? 32'd1 : 32'd9);
            check("quotient", 32'(quotient), 32'(eq));
            check("remainder", 32'(remainder), 32'(er));
            check("dbz", 32'(dbz), 32'(ez));
            @(posedge clk);
            @(negedge clk);
            check("done_pulse_end", 32'(done), 32'd0);
            check("busy_after", 32'(busy), 32'd0);
            check("chk_err", 32'(chk_err), 32'd0);
            check("quotient_hold", 32'(quotient), 32'(eq));
        end
    endtask

    task automatic do_model_op(input logic [W-1:0] a, input logic [N-1:0] b);
        logic [W-1:0] q;
        logic [N-1:0] r;
        logic         z;
        ref_div(a, b, q, r, z);
        do_op(a, b, q, r, z, -1);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{a: 8'd200, b: 4'd13, q: 8'd15,  r: 4'd5,  z: 1'b0};
        vecs[1] = '{a: 8'd255, b: 4'd15, q: 8'd17,  r: 4'd0,  z: 1'b0};
        vecs[2] = '{a: 8'd225, b: 4'd1,  q: 8'd225, r: 4'd0,  z: 1'b0};
        vecs[3] = '{a: 8'd7,   b: 4'd9,  q: 8'd0,   r: 4'd7,  z: 1'b0};
        vecs[4] = '{a: 8'd100, b: 4'd0,  q: 8'd255, r: 4'd4,  z: 1'b1};
        vecs[5] = '{a: 8'd200, b: 4'd13, q: 8'd15,  r: 4'd5,  z: 1'b0};
        vecs[6] = '{a: 8'd0,   b: 4'd5,  q: 8'd0,   r: 4'd0,  z: 1'b0};
        vecs[7] = '{a: 8'd1,   b: 4'd15, q: 8'd0,   r: 4'd1,  z: 1'b0};
        vecs[8] = '{a: 8'd0,   b: 4'd0,  q: 8'd255, r: 4'd0,  z: 1'b1};
        vecs[9] = '{a: 8'd254, b: 4'd2,  q: 8'd127, r: 4'd0,  z: 1'b0};

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(dbz), 32'd0);
        check("rst_chk_err", 32'(chk_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table vectors, issued back-to-back
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, -1);
        end

        // start pulsed during RUN must be ignored: still 7/9 and one done
        begin
            int extra;
            do_op(8'd7, 4'd9, 8'd0, 4'd7, 1'b0, 3);
            extra = 0;
            repeat (12) begin
                @(negedge clk);
                if (done) extra++;
            end
            check("no_extra_done", 32'(extra), 32'd0);
            check("ignored_q", 32'(quotient), 32'd0);
            check("ignored_r", 32'(remainder), 32'd7);
        end

        // Reset in the middle of 200/13 aborts without a done
        begin
            int dn;
            start    = 1'b1;
            dividend = 8'd200;
            divisor  = 4'd13;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_q", 32'(quotient), 32'd0);
            check("abort_r", 32'(remainder), 32'd0);
            dn = 0;
            repeat (12) begin
                if (done) dn++;
                @(negedge clk);
            end
            check("abort_no_done", 32'(dn), 32'd0);
            do_op(8'd200, 4'd13, 8'd15, 4'd5, 1'b0, -1);
        end

        // Exhaustive sweep over every operand pair, including divisor 0
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_model_op(W'(a), N'(b));
            end
        end

        // Randomized operations with occasional divide-by-zero
        for (int k = 0; k < 200; k++) begin
            logic [W-1:0] ra;
            logic [N-1:0] rb;
            ra = W'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(1, 15));
            do_model_op(ra, rb);
        end

        check("chk_err_never", 32'(chk_err_hits), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
